// File: rtl/assoc_cache.sv
// Set-associative write-back, write-allocate cache with round-robin replacement.
// Hits complete combinationally; misses stall through WRITEBACK/REFILL; Flush cleans every dirty line.
module assoc_cache #(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [31:0]           Addr,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  Flush,
  output logic                  Hit,
  output logic [DATA_WIDTH-1:0] Data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  memory_ready,
  output logic                  flush_done,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WB     = 2'd1;
  localparam logic [1:0] S_REFILL = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  logic [WAYS-1:0]       r_valid [SETS];
  logic [WAYS-1:0]       r_dirty [SETS];
  logic [TAG_W-1:0]      r_tag   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] r_data  [SETS][WAYS];
  logic [WAY_W-1:0]      r_rr    [SETS];

  logic [1:0]            r_state;
  logic                  r_mem_req, r_mem_we, r_flush_done;
  logic [31:0]           r_mem_addr, r_hit_cnt, r_miss_cnt;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [IDX_W-1:0]      r_fset, r_ridx;
  logic [WAY_W-1:0]      r_fway, r_vway;
  logic [TAG_W-1:0]      r_rtag;

  logic [IDX_W-1:0]      w_idx, w_fset_nx, w_ridx_nx;
  logic [TAG_W-1:0]      w_tag, w_rtag_nx, w_victim_tag;
  logic                  w_access, w_hit_any, w_inv_found, w_victim_dirty;
  logic [WAY_W-1:0]      w_hit_way, w_victim, w_fway_nx, w_vway_nx;
  logic [DATA_WIDTH-1:0] w_hit_data, w_victim_data, w_wdata_nx;
  logic [1:0]            w_state_nx;
  logic                  w_req_nx, w_we_nx, w_fdone_nx;
  logic [31:0]           w_addr_nx;
  logic                  w_hit, w_hit_evt, w_wr_hit, w_miss, w_fill, w_fclean, w_fadv;

  assign w_idx    = Addr[IDX_W+1:2];
  assign w_tag    = Addr[31:IDX_W+2];
  assign w_access = MemRead | MemWrite;

  assign Hit        = w_hit;
  assign Data       = w_hit_data;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign flush_done = r_flush_done;
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

  // Tag lookup in the addressed set.
  always_comb begin
    w_hit_any  = 1'b0;
    w_hit_way  = '0;
    w_hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_hit_any && r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit_any  = 1'b1;
        w_hit_way  = WAY_W'(w);
        w_hit_data = r_data[w_idx][w];
      end
    end
  end

  // Victim: lowest invalid way, else the set's round-robin pointer.
  always_comb begin
    w_inv_found = 1'b0;
    w_victim    = r_rr[w_idx];
    for (int w = 0; w < WAYS; w++) begin
      if (!w_inv_found && !r_valid[w_idx][w]) begin
        w_inv_found = 1'b1;
        w_victim    = WAY_W'(w);
      end
    end
    w_victim_dirty = r_valid[w_idx][w_victim] & r_dirty[w_idx][w_victim];
    w_victim_tag   = r_tag[w_idx][w_victim];
    w_victim_data  = r_data[w_idx][w_victim];
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nx = r_state;
    w_req_nx   = r_mem_req;
    w_we_nx    = r_mem_we;
    w_addr_nx  = r_mem_addr;
    w_wdata_nx = r_mem_wdata;
    w_fdone_nx = 1'b0;
    w_fset_nx  = r_fset;
    w_fway_nx  = r_fway;
    w_ridx_nx  = r_ridx;
    w_rtag_nx  = r_rtag;
    w_vway_nx  = r_vway;
    w_hit      = 1'b0;
    w_hit_evt  = 1'b0;
    w_wr_hit   = 1'b0;
    w_miss     = 1'b0;
    w_fill     = 1'b0;
    w_fclean   = 1'b0;
    w_fadv     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Flush) begin
          w_state_nx = S_FLUSH;
          w_fset_nx  = '0;
          w_fway_nx  = '0;
        end else if (!w_access) begin
          w_hit = 1'b1;
        end else if (w_hit_any) begin
          w_hit     = 1'b1;
          w_hit_evt = 1'b1;
          w_wr_hit  = MemWrite;
        end else begin
          w_miss    = 1'b1;
          w_ridx_nx = w_idx;
          w_rtag_nx = w_tag;
          w_vway_nx = w_victim;
          w_req_nx  = 1'b1;
          if (w_victim_dirty) begin
            w_state_nx = S_WB;
            w_we_nx    = 1'b1;
            w_addr_nx  = {w_victim_tag, w_idx, 2'b00};
            w_wdata_nx = w_victim_data;
          end else begin
            w_state_nx = S_REFILL;
            w_we_nx    = 1'b0;
            w_addr_nx  = Addr & 32'hFFFF_FFFC;
          end
        end
      end
      S_WB: begin
        if (memory_ready) begin
          w_state_nx = S_REFILL;
          w_we_nx    = 1'b0;
          w_addr_nx  = {r_rtag, r_ridx, 2'b00};
        end
      end
      S_REFILL: begin
        if (memory_ready) begin
          w_state_nx = S_IDLE;
          w_req_nx   = 1'b0;
          w_fill     = 1'b1;
        end
      end
      default: begin
        if (r_mem_req) begin
          if (memory_ready) begin
            w_req_nx = 1'b0;
            w_fclean = 1'b1;
            w_fadv   = 1'b1;
          end
        end else if (r_valid[r_fset][r_fway] && r_dirty[r_fset][r_fway]) begin
          w_req_nx   = 1'b1;
          w_we_nx    = 1'b1;
          w_addr_nx  = {r_tag[r_fset][r_fway], r_fset, 2'b00};
          w_wdata_nx = r_data[r_fset][r_fway];
        end else begin
          w_fadv = 1'b1;
        end
      end
    endcase
    if (w_fadv) begin
      if (r_fway == WAY_W'(WAYS - 1)) begin
        w_fway_nx = '0;
        if (r_fset == IDX_W'(SETS - 1)) begin
          w_state_nx = S_IDLE;
          w_fdone_nx = 1'b1;
        end else begin
          w_fset_nx = r_fset + IDX_W'(1);
        end
      end else begin
        w_fway_nx = r_fway + WAY_W'(1);
      end
    end
  end

  // Control state, memory port and counters.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state      <= S_IDLE;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_flush_done <= 1'b0;
      r_fset       <= '0;
      r_fway       <= '0;
      r_ridx       <= '0;
      r_rtag       <= '0;
      r_vway       <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_mem_req    <= w_req_nx;
      r_mem_we     <= w_we_nx;
      r_mem_addr   <= w_addr_nx;
      r_mem_wdata  <= w_wdata_nx;
      r_flush_done <= w_fdone_nx;
      r_fset       <= w_fset_nx;
      r_fway       <= w_fway_nx;
      r_ridx       <= w_ridx_nx;
      r_rtag       <= w_rtag_nx;
      r_vway       <= w_vway_nx;
      if (w_hit_evt && (r_hit_cnt != 32'hFFFF_FFFF)) r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_miss && (r_miss_cnt != 32'hFFFF_FFFF)) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  // Line status bits and replacement pointers.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      if (w_wr_hit) r_dirty[w_idx][w_hit_way] <= 1'b1;
      if (w_miss && !w_inv_found)
        r_rr[w_idx] <= (r_rr[w_idx] == WAY_W'(WAYS - 1)) ? '0 : r_rr[w_idx] + WAY_W'(1);
      if (w_fill) begin
        r_valid[r_ridx][r_vway] <= 1'b1;
        r_dirty[r_ridx][r_vway] <= 1'b0;
      end
      if (w_fclean) r_dirty[r_fset][r_fway] <= 1'b0;
    end
  end

  // Tag and data arrays need no reset: valid bits gate every use.
  always_ff @(posedge CLK) begin
    if (w_wr_hit) r_data[w_idx][w_hit_way] <= WriteData;
    if (w_fill) begin
      r_data[r_ridx][r_vway] <= mem_rdata;
      r_tag[r_ridx][r_vway]  <= r_rtag;
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Bench for assoc_cache (WAYS=2, SETS=4) against a transaction-level cache model,
// plus a direct-mapped (WAYS=1) conflict check.
module tb_assoc_cache;

  typedef struct {
    bit          hit;
    logic [31:0] data;
    int          n_wb;
    logic [31:0] wb_addr;
    logic [31:0] wb_data;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wdata;
    bit          e_hit;
    logic [31:0] e_data;
    int          e_wb;
    logic [31:0] e_wb_addr;
    logic [31:0] e_wb_data;
  } vec_t;

  logic        clk, rst_n;
  logic [31:0] addr, wdata, data, mem_addr, mem_wdata, mem_rdata, hit_count, miss_count;
  logic        mem_read, mem_write, flush, hit, mem_req, mem_we, memory_ready, flush_done;

  logic [31:0] dm_addr, dm_data, dm_mem_addr, dm_mem_wdata, dm_mem_rdata, dm_hit_count, dm_miss_count;
  logic        dm_rd, dm_hit, dm_mem_req, dm_mem_we, dm_ready, dm_flush_done;

  int checks = 0;
  int failures = 0;
  int lat = 3;

  logic [31:0] dut_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
  logic [31:0] fl_addr_q[$], fl_data_q[$];

  // Reference model state: 4 sets x 2 ways
  bit          m_valid [4][2];
  bit          m_dirty [4][2];
  logic [27:0] m_tag   [4][2];
  logic [31:0] m_data  [4][2];
  int          m_rr    [4];
  int unsigned m_hits, m_misses;

  assoc_cache #(.WAYS(2), .SETS(4), .DATA_WIDTH(32)) u_dut (
    .CLK(clk), .Reset(rst_n), .Addr(addr), .MemRead(mem_read), .MemWrite(mem_write),
    .WriteData(wdata), .Flush(flush), .Hit(hit), .Data(data), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .memory_ready(memory_ready), .flush_done(flush_done), .hit_count(hit_count),
    .miss_count(miss_count)
  );

  assoc_cache #(.WAYS(1), .SETS(4), .DATA_WIDTH(32)) u_dm (
    .CLK(clk), .Reset(rst_n), .Addr(dm_addr), .MemRead(dm_rd), .MemWrite(1'b0),
    .WriteData(32'h0), .Flush(1'b0), .Hit(dm_hit), .Data(dm_data), .mem_req(dm_mem_req),
    .mem_we(dm_mem_we), .mem_addr(dm_mem_addr), .mem_wdata(dm_mem_wdata),
    .mem_rdata(dm_mem_rdata), .memory_ready(dm_ready), .flush_done(dm_flush_done),
    .hit_count(dm_hit_count), .miss_count(dm_miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] dut_mem_rd(input logic [31:0] a);
    return dut_mem.exists(a) ? dut_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_mem_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Memory responder for the main DUT: ready after 'lat' cycles of mem_req
  initial begin
    int cnt;
    cnt = 0;
    memory_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || memory_ready) begin
        memory_ready = 1'b0;
        cnt = 0;
      end else if (mem_req) begin
        cnt++;
        if (cnt >= lat) begin
          memory_ready = 1'b1;
          if (mem_we) begin
            dut_mem[mem_addr] = mem_wdata;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
          end else begin
            mem_rdata = dut_mem_rd(mem_addr);
            rd_addr_q.push_back(mem_addr);
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < 4; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
    m_hits = 0;
    m_misses = 0;
  endfunction

  // One complete access: miss handling (if any) followed by the retried hit
  function automatic void model_step(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                                     output exp_t e);
    logic [1:0]  idx;
    logic [27:0] tg;
    int hw, v;
    idx = a[3:2];
    tg  = a[31:4];
    e.hit = 1'b0; e.data = '0; e.n_wb = 0; e.wb_addr = '0; e.wb_data = '0;
    hw = -1;
    for (int w = 0; w < 2; w++)
      if (hw < 0 && m_valid[idx][w] && m_tag[idx][w] == tg) hw = w;
    if (hw >= 0) begin
      e.hit = 1'b1;
    end else begin
      m_misses++;
      v = -1;
      for (int w = 0; w < 2; w++)
        if (v < 0 && !m_valid[idx][w]) v = w;
      if (v < 0) begin
        v = m_rr[idx];
        m_rr[idx] = (m_rr[idx] + 1) % 2;
      end
      if (m_valid[idx][v] && m_dirty[idx][v]) begin
        e.n_wb    = 1;
        e.wb_addr = {m_tag[idx][v], idx, 2'b00};
        e.wb_data = m_data[idx][v];
        ref_mem[e.wb_addr] = e.wb_data;
      end
      m_valid[idx][v] = 1'b1;
      m_dirty[idx][v] = 1'b0;
      m_tag[idx][v]   = tg;
      m_data[idx][v]  = ref_mem_rd(a & 32'hFFFF_FFFC);
      hw = v;
    end
    m_hits++;
    if (wr) begin
      m_data[idx][hw]  = wd;
      m_dirty[idx][hw] = 1'b1;
    end
    e.data = m_data[idx][hw];
  endfunction

  function automatic void model_flush();
    fl_addr_q.delete();
    fl_data_q.delete();
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 2; w++)
        if (m_valid[s][w] && m_dirty[s][w]) begin
          fl_addr_q.push_back({m_tag[s][w], 2'(s), 2'b00});
          fl_data_q.push_back(m_data[s][w]);
          ref_mem[{m_tag[s][w], 2'(s), 2'b00}] = m_data[s][w];
          m_dirty[s][w] = 1'b0;
        end
  endfunction

  // Called at posedge+1; returns at posedge+1 after the access completes
  task automatic do_access(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                           input exp_t e, input string nm);
    bit first;
    int n;
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    addr = a; mem_read = !wr; mem_write = wr; wdata = wd;
    @(negedge clk);
    first = hit;
    n = 0;
    while (!hit && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, 32'(hit), 32'd1);
    chk({nm, "_first_hit"}, 32'(first), 32'(e.hit));
    if (!wr) chk({nm, "_data"}, data, e.data);
    chk({nm, "_n_wb"}, 32'(wr_addr_q.size()), 32'(e.n_wb));
    if (e.n_wb == 1 && wr_addr_q.size() == 1) begin
      chk({nm, "_wb_addr"}, wr_addr_q[0], e.wb_addr);
      chk({nm, "_wb_data"}, wr_data_q[0], e.wb_data);
    end
    chk({nm, "_n_refill"}, 32'(rd_addr_q.size()), e.hit ? 32'd0 : 32'd1);
    if (!e.hit && rd_addr_q.size() == 1)
      chk({nm, "_refill_addr"}, rd_addr_q[0], a & 32'hFFFF_FFFC);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic model_access(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                              input string nm);
    exp_t e;
    model_step(a, wr, wd, e);
    do_access(a, wr, wd, e, nm);
  endtask

  task automatic do_flush(input string nm);
    int n, pulses;
    model_flush();
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    flush = 1'b1;
    @(negedge clk);
    chk({nm, "_hit_low"}, 32'(hit), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    n = 0;
    pulses = 0;
    while (pulses == 0 && n < 500) begin
      @(negedge clk);
      if (flush_done) pulses++;
      n++;
    end
    repeat (4) begin
      @(negedge clk);
      if (flush_done) pulses++;
    end
    chk({nm, "_done_pulses"}, 32'(pulses), 32'd1);
    chk({nm, "_n_writes"}, 32'(wr_addr_q.size()), 32'(fl_addr_q.size()));
    chk({nm, "_n_reads"}, 32'(rd_addr_q.size()), 32'd0);
    for (int i = 0; i < fl_addr_q.size() && i < wr_addr_q.size(); i++) begin
      chk($sformatf("%s_w%0d_addr", nm, i), wr_addr_q[i], fl_addr_q[i]);
      chk($sformatf("%s_w%0d_data", nm, i), wr_data_q[i], fl_data_q[i]);
    end
    @(posedge clk); #1;
  endtask

  task automatic dm_access(input logic [31:0] a, input string nm);
    bit first;
    int n;
    dm_addr = a; dm_rd = 1'b1;
    @(negedge clk);
    first = dm_hit;
    n = 0;
    while (!dm_hit && n < 50) begin
      dm_mem_rdata = dm_mem_addr ^ 32'hC0DE_0000;
      dm_ready = dm_mem_req && !dm_ready;
      @(negedge clk);
      n++;
    end
    dm_ready = 1'b0;
    chk({nm, "_first_hit"}, 32'(first), 32'd0);
    chk({nm, "_done"}, 32'(dm_hit), 32'd1);
    chk({nm, "_data"}, dm_data, (a & 32'hFFFF_FFFC) ^ 32'hC0DE_0000);
    @(posedge clk); #1;
    dm_rd = 1'b0;
  endtask

  initial begin
    vec_t tbl [7];
    exp_t e, dummy;
    int n;
    logic [31:0] a, wd;

    tbl[0] = '{32'h100, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 0, 32'h0,   32'h0};
    tbl[1] = '{32'h100, 1'b1, 32'h12345678, 1'b1, 32'h12345678, 0, 32'h0,   32'h0};
    tbl[2] = '{32'h100, 1'b0, 32'h0,        1'b1, 32'h12345678, 0, 32'h0,   32'h0};
    tbl[3] = '{32'h110, 1'b0, 32'h0,        1'b0, 32'h11110000, 0, 32'h0,   32'h0};
    tbl[4] = '{32'h120, 1'b0, 32'h0,        1'b0, 32'h22220000, 1, 32'h100, 32'h12345678};
    tbl[5] = '{32'h100, 1'b0, 32'h0,        1'b0, 32'h12345678, 0, 32'h0,   32'h0};
    tbl[6] = '{32'h110, 1'b0, 32'h0,        1'b0, 32'h11110000, 0, 32'h0,   32'h0};

    dut_mem[32'h100] = 32'hDEADBEEF; ref_mem[32'h100] = 32'hDEADBEEF;
    dut_mem[32'h110] = 32'h11110000; ref_mem[32'h110] = 32'h11110000;
    dut_mem[32'h120] = 32'h22220000; ref_mem[32'h120] = 32'h22220000;

    rst_n = 1'b0; addr = '0; mem_read = 1'b0; mem_write = 1'b0; wdata = '0; flush = 1'b0;
    dm_addr = '0; dm_rd = 1'b0; dm_ready = 1'b0; dm_mem_rdata = '0;
    model_reset();
    #3;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hit", 32'(hit), 32'd1);
    @(posedge clk); #1;

    // Directed table: cold miss, write hit, dirty eviction, round-robin
    for (int i = 0; i < 7; i++) begin
      model_step(tbl[i].addr, tbl[i].wr, tbl[i].wdata, dummy);
      e.hit = tbl[i].e_hit; e.data = tbl[i].e_data; e.n_wb = tbl[i].e_wb;
      e.wb_addr = tbl[i].e_wb_addr; e.wb_data = tbl[i].e_wb_data;
      do_access(tbl[i].addr, tbl[i].wr, tbl[i].wdata, e, $sformatf("vec%0d", i));
      if (i == 0) chk("cold_miss_count", miss_count, 32'd1);
    end
    chk("tbl_hit_count", hit_count, 32'd7);
    chk("tbl_miss_count", miss_count, 32'd5);

    // Flush of two dirty lines, then both hit without memory traffic
    model_access(32'h100, 1'b1, 32'hAAAA0001, "fl_wr0");
    model_access(32'h104, 1'b1, 32'hBBBB0002, "fl_wr1");
    do_flush("flush");
    chk("flush_two_writes", 32'(wr_addr_q.size()), 32'd2);
    model_access(32'h100, 1'b0, 32'h0, "fl_rd0");
    model_access(32'h104, 1'b0, 32'h0, "fl_rd1");

    // Reset during REFILL aborts the transaction and empties the cache
    lat = 10;
    addr = 32'h200; mem_read = 1'b1;
    n = 0;
    while (!(mem_req && !mem_we) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_refill_started", 32'(mem_req && !mem_we), 32'd1);
    chk("rst_refill_addr", mem_addr, 32'h200);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_mem_addr", mem_addr, 32'd0);
    chk("rst_mid_miss_count", miss_count, 32'd0);
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    lat = 3;
    model_access(32'h200, 1'b0, 32'h0, "post_rst_200");
    model_access(32'h104, 1'b0, 32'h0, "post_rst_104");

    // Randomized accesses and flushes against the model
    for (int i = 0; i < 250; i++) begin
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 19) == 0) begin
        do_flush($sformatf("rflush%0d", i));
      end else begin
        a  = ($urandom_range(0, 5) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
        wd = $urandom;
        model_access(a, $urandom_range(0, 1) == 1, wd, $sformatf("rnd%0d", i));
      end
    end
    chk("rnd_hit_count", hit_count, 32'(m_hits));
    chk("rnd_miss_count", miss_count, 32'(m_misses));

    // Direct-mapped conflict: every alternating access misses
    for (int i = 0; i < 6; i++)
      dm_access((i % 2 == 0) ? 32'h100 : 32'h110, $sformatf("dm%0d", i));
    chk("dm_miss_count", dm_miss_count, 32'd6);
    chk("dm_hit_count", dm_hit_count, 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
